ldst_dma_unit: RTL and testbench
================================

LDST_DMA_UNIT -- requirements
Module: ldst_dma_unit

Interface
REQ-001 Parameter WIDTH_DATA, 32, data word width.
REQ-002 Parameter WIDTH_ADDR, 10, memory address width.
REQ-003 Parameter WIDTH_LENGTH, 10, descriptor word-count width.
REQ-004 Parameter NUM_CH, 2, command channels (1..8).
REQ-005 Parameter DEPTH_RET, 4, load-return FIFO depth (power of 2, >=2).
REQ-006 Ports (per-channel ports are NUM_CH-wide vectors or NUM_CH arrays):
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- I_Cmd_Valid  in  NUM_CH  descriptor offered.
- O_Cmd_Ready  out  NUM_CH  descriptor accepted.
- I_Cmd_Dir  in  NUM_CH  0 = load, 1 = store.
- I_Cmd_Base  in  NUM_CH x WIDTH_ADDR  start address.
- I_Cmd_Stride  in  NUM_CH x WIDTH_ADDR  address increment.
- I_Cmd_Length  in  NUM_CH x WIDTH_LENGTH  word count.
- I_St_Valid / I_St_Data  in  NUM_CH / NUM_CH x WIDTH_DATA  store data.
- O_St_Ready  out  NUM_CH  store word consumed.
- O_Ld_Valid / O_Ld_Data / O_Ld_Last  out  NUM_CH / NUM_CH x WIDTH_DATA / NUM_CH  load data.
- I_Ld_Ready  in  NUM_CH  load data taken.
- O_Done  out  NUM_CH  one-cycle descriptor-complete pulse.
- O_Mem_Req / O_Mem_We / O_Mem_Addr / O_Mem_WData  out  1 / 1 / WIDTH_ADDR / WIDTH_DATA  memory request.
- I_Mem_Gnt  in  1  request accepted this cycle.
- I_Mem_RValid / I_Mem_RData  in  1 / WIDTH_DATA  in-order read return; no backpressure.
- O_Busy  out  1  descriptor in progress.

Function
REQ-007 FSM states IDLE, RUN, DRAIN, DONE; one descriptor active at a time.
REQ-008 IDLE: round-robin over I_Cmd_Valid, starting at the channel after the last granted; after reset, channel 0 has priority. O_Cmd_Ready[g] is asserted combinationally for the winner only; the handshake latches the descriptor and the FSM goes to RUN, or to DONE if length is 0.
REQ-009 Address of word k = Base + k*Stride, computed by accumulation and truncated to WIDTH_ADDR (wraps modulo 2^WIDTH_ADDR).
REQ-010 Store RUN: O_Mem_Req = I_St_Valid[g]; O_Mem_We = 1; O_St_Ready[g] = O_Mem_Req & I_Mem_Gnt. Each grant consumes one word and advances the address. After the last grant the FSM goes to DONE.
REQ-011 Load RUN: O_Mem_Req = 1 only while credit > 0, where credit = DEPTH_RET - fifo_count - outstanding. outstanding increments on grant and decrements on I_Mem_RValid; both in the same cycle leave it unchanged. After the last grant the FSM goes to DRAIN.
REQ-012 Read returns are written into the return FIFO; a return arriving while the FIFO is full is a protocol violation and is precluded by the credit rule.
REQ-013 FIFO head drives O_Ld_Valid[g] and O_Ld_Data[g]. A pop occurs on O_Ld_Valid[g] & I_Ld_Ready[g]. Push and pop in the same cycle keep the count unchanged. Empty-FIFO bypass is not permitted, so minimum return-to-output latency is 1 cycle.
REQ-014 O_Ld_Last[g] is high with the Length-th popped word only.
REQ-015 DRAIN: leave when outstanding = 0 and the FIFO is empty, then go to DONE.
REQ-016 DONE: one cycle; O_Done[g] = 1; go to IDLE; the round-robin pointer is set to g.
REQ-017 All outputs of non-granted channels are 0. O_Mem_Addr and O_Mem_WData are 0 when O_Mem_Req = 0.
REQ-018 O_Busy = (state != IDLE).
REQ-019 A zero-length descriptor performs no memory access; O_Done pulses the cycle after acceptance.
REQ-020 Length = 2^WIDTH_LENGTH-1 is supported; word counters are WIDTH_LENGTH wide and never overflow.

Reset
REQ-021 When reset is high at a clock edge, the block shall:
- set state = IDLE, round-robin pointer = 0, outstanding = 0, FIFO empty;
- drive every output to 0 on the following cycle;
- hold all outputs at 0 while reset stays high.
REQ-022 Reset mid-descriptor abandons the descriptor without O_Done. Read returns arriving after reset are discarded while state = IDLE with outstanding = 0.

Verification
REQ-023 Store, ch0: Base=0x010, Stride=2, Length=3, I_Mem_Gnt always 1, data A,B,C -> writes to 0x010/0x012/0x014 on 3 consecutive cycles; O_Done[0] pulses on the next cycle.
REQ-024 Load, ch1: Base=0x3FE, Stride=1, Length=4, read latency 2, I_Ld_Ready=1 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; data delivered in order; O_Ld_Last on the 4th word only.
REQ-025 Load with I_Ld_Ready=0 for 10 cycles, DEPTH_RET=4 -> at most 4 grants issued, then O_Mem_Req stays low until a pop occurs.
REQ-026 ch0 and ch1 both valid from reset, each Length=1 -> ch0 served first, then ch1; if ch0 re-requests, ch1 is served before ch0's second descriptor.
REQ-027 Length=0 on ch0 -> no O_Mem_Req; O_Done[0] asserted 1 cycle after O_Cmd_Ready[0].
REQ-028 Reset asserted with 2 reads outstanding -> all outputs 0 on the next cycle; later I_Mem_RValid produces no O_Ld_Valid.

Source files
------------

// File: rtl/ldst_dma_unit.sv
// ldst_dma_unit: one strided load/store DMA engine shared by NUM_CH command
// channels. Loads are credit-limited so read returns always fit the return FIFO.

// Per-channel output stage: only the channel that owns the engine sees activity.
module ldst_dma_lane #(
  parameter int WIDTH_DATA = 32
) (
  input  logic                  sel,
  input  logic                  cmd_win,
  input  logic                  st_ready,
  input  logic                  ld_valid,
  input  logic [WIDTH_DATA-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  done,
  output logic                  lane_cmd_ready,
  output logic                  lane_st_ready,
  output logic                  lane_ld_valid,
  output logic [WIDTH_DATA-1:0] lane_ld_data,
  output logic                  lane_ld_last,
  output logic                  lane_done
);
  // gate shared engine signals down to this lane
  always_comb begin
    lane_cmd_ready = cmd_win;
    lane_st_ready  = sel & st_ready;
    lane_ld_valid  = sel & ld_valid;
    lane_ld_data   = (sel & ld_valid) ? ld_data : '0;
    lane_ld_last   = sel & ld_valid & ld_last;
    lane_done      = sel & done;
  end
endmodule

module ldst_dma_unit #(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_ADDR   = 10,
  parameter int WIDTH_LENGTH = 10,
  parameter int NUM_CH       = 2,
  parameter int DEPTH_RET    = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_CH-1:0]                    I_Cmd_Valid,
  output logic [NUM_CH-1:0]                    O_Cmd_Ready,
  input  logic [NUM_CH-1:0]                    I_Cmd_Dir,
  input  logic [NUM_CH-1:0][WIDTH_ADDR-1:0]    I_Cmd_Base,
  input  logic [NUM_CH-1:0][WIDTH_ADDR-1:0]    I_Cmd_Stride,
  input  logic [NUM_CH-1:0][WIDTH_LENGTH-1:0]  I_Cmd_Length,
  input  logic [NUM_CH-1:0]                    I_St_Valid,
  input  logic [NUM_CH-1:0][WIDTH_DATA-1:0]    I_St_Data,
  output logic [NUM_CH-1:0]                    O_St_Ready,
  output logic [NUM_CH-1:0]                    O_Ld_Valid,
  output logic [NUM_CH-1:0][WIDTH_DATA-1:0]    O_Ld_Data,
  output logic [NUM_CH-1:0]                    O_Ld_Last,
  input  logic [NUM_CH-1:0]                    I_Ld_Ready,
  output logic [NUM_CH-1:0]                    O_Done,
  output logic                                 O_Mem_Req,
  output logic                                 O_Mem_We,
  output logic [WIDTH_ADDR-1:0]                O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]                O_Mem_WData,
  input  logic                                 I_Mem_Gnt,
  input  logic                                 I_Mem_RValid,
  input  logic [WIDTH_DATA-1:0]                I_Mem_RData,
  output logic                                 O_Busy
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH_RET);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                    dir;
    logic [WIDTH_ADDR-1:0]   stride;
    logic [WIDTH_LENGTH-1:0] len;
  } desc_t;

  state_t                  state, state_nxt;
  desc_t                   desc;
  logic [CW-1:0]           g, rr_ptr, win_idx;
  logic                    rr_seen, win_found;
  int                      rr_start;
  logic [WIDTH_ADDR-1:0]   addr;
  logic [WIDTH_LENGTH-1:0] iss_cnt, pop_cnt;
  logic [NW-1:0]           outst, fcnt;
  logic [AW-1:0]           wp, rp;
  logic [WIDTH_DATA-1:0]   ret_mem [DEPTH_RET];
  logic [NW:0]             inflight;
  logic                    credit_ok, cmd_take, mem_req, mem_we, ld_vld, done;
  logic                    grant, ld_grant, last_grant, st_rdy, ld_last, pop, push;

  // credit = DEPTH_RET - fifo_count - outstanding, kept non-negative by construction
  assign inflight   = {1'b0, fcnt} + {1'b0, outst};
  assign credit_ok  = inflight < (NW+1)'(DEPTH_RET);
  assign grant      = mem_req & I_Mem_Gnt;
  assign ld_grant   = grant & ~desc.dir;
  assign st_rdy     = grant & desc.dir;
  assign last_grant = grant && (iss_cnt == desc.len - WIDTH_LENGTH'(1));
  assign ld_last    = ld_vld && (pop_cnt == desc.len - WIDTH_LENGTH'(1));
  assign pop        = ld_vld & I_Ld_Ready[g];
  // returns with nothing outstanding belong to an abandoned descriptor
  assign push       = I_Mem_RValid & (outst != '0);

  // round-robin pick: search starts after the last served channel, ch0 after reset
  always_comb begin
    rr_start = 0;
    if (rr_seen) rr_start = int'(rr_ptr) + 1;
    if (rr_start >= NUM_CH) rr_start = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!win_found && i >= rr_start && I_Cmd_Valid[i]) begin
        win_found = 1'b1;
        win_idx   = CW'(i);
      end
    for (int i = 0; i < NUM_CH; i++)
      if (!win_found && i < rr_start && I_Cmd_Valid[i]) begin
        win_found = 1'b1;
        win_idx   = CW'(i);
      end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_take) state_nxt = (I_Cmd_Length[win_idx] == '0) ? DONE : RUN;
      RUN:     if (last_grant) state_nxt = desc.dir ? DONE : DRAIN;
      DRAIN:   if (outst == '0 && fcnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_take = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ld_vld   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: cmd_take = win_found & ~reset;
      RUN: begin
        if (desc.dir) begin
          mem_req = I_St_Valid[g];
          mem_we  = 1'b1;
        end else begin
          mem_req = credit_ok;
          ld_vld  = fcnt != '0;
        end
      end
      DRAIN:   ld_vld = fcnt != '0;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // descriptor latch, address accumulator, word counters, arbitration pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      desc    <= '0;
      g       <= '0;
      rr_ptr  <= '0;
      rr_seen <= 1'b0;
      addr    <= '0;
      iss_cnt <= '0;
      pop_cnt <= '0;
    end else begin
      if (cmd_take) begin
        g           <= win_idx;
        desc.dir    <= I_Cmd_Dir[win_idx];
        desc.stride <= I_Cmd_Stride[win_idx];
        desc.len    <= I_Cmd_Length[win_idx];
        addr        <= I_Cmd_Base[win_idx];
        iss_cnt     <= '0;
        pop_cnt     <= '0;
      end
      if (grant) begin
        addr    <= addr + desc.stride;
        iss_cnt <= iss_cnt + WIDTH_LENGTH'(1);
      end
      if (pop) pop_cnt <= pop_cnt + WIDTH_LENGTH'(1);
      if (state == DONE) begin
        rr_ptr  <= g;
        rr_seen <= 1'b1;
      end
    end
  end

  // outstanding-read count and return FIFO pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      outst <= '0;
      fcnt  <= '0;
      wp    <= '0;
      rp    <= '0;
    end else begin
      case ({ld_grant, push})
        2'b10:   outst <= outst + NW'(1);
        2'b01:   outst <= outst - NW'(1);
        default: ;
      endcase
      case ({push, pop})
        2'b10:   fcnt <= fcnt + NW'(1);
        2'b01:   fcnt <= fcnt - NW'(1);
        default: ;
      endcase
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
    end
  end

  // return FIFO storage; contents are don't-care while empty
  always_ff @(posedge clock) begin
    if (push) ret_mem[wp] <= I_Mem_RData;
  end

  assign O_Mem_Req   = mem_req;
  assign O_Mem_We    = mem_we;
  assign O_Mem_Addr  = mem_req ? addr : '0;
  assign O_Mem_WData = (mem_req & desc.dir) ? I_St_Data[g] : '0;
  assign O_Busy      = state != IDLE;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    ldst_dma_lane #(.WIDTH_DATA(WIDTH_DATA)) u_lane (
      .sel            (g == CW'(i)),
      .cmd_win        (cmd_take && (win_idx == CW'(i))),
      .st_ready       (st_rdy),
      .ld_valid       (ld_vld),
      .ld_data        (ret_mem[rp]),
      .ld_last        (ld_last),
      .done           (done),
      .lane_cmd_ready (O_Cmd_Ready[i]),
      .lane_st_ready  (O_St_Ready[i]),
      .lane_ld_valid  (O_Ld_Valid[i]),
      .lane_ld_data   (O_Ld_Data[i]),
      .lane_ld_last   (O_Ld_Last[i]),
      .lane_done      (O_Done[i])
    );
  end
endmodule

// File: tb/tb_ldst_dma_unit.sv
// Directed bench for ldst_dma_unit: store, load, backpressure, zero length,
// arbitration order and reset mid-descriptor.
module tb_ldst_dma_unit;
  localparam int WD = 32, WA = 10, WL = 10, NC = 2, DR = 4;

  logic clock = 1'b0;
  logic reset;
  logic [NC-1:0]         I_Cmd_Valid, O_Cmd_Ready, I_Cmd_Dir;
  logic [NC-1:0][WA-1:0] I_Cmd_Base, I_Cmd_Stride;
  logic [NC-1:0][WL-1:0] I_Cmd_Length;
  logic [NC-1:0]         I_St_Valid, O_St_Ready, O_Ld_Valid, O_Ld_Last, I_Ld_Ready, O_Done;
  logic [NC-1:0][WD-1:0] I_St_Data, O_Ld_Data;
  logic                  O_Mem_Req, O_Mem_We, I_Mem_Gnt, I_Mem_RValid, O_Busy;
  logic [WA-1:0]         O_Mem_Addr;
  logic [WD-1:0]         O_Mem_WData, I_Mem_RData;

  ldst_dma_unit #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .WIDTH_LENGTH(WL),
                  .NUM_CH(NC), .DEPTH_RET(DR)) dut (
    .clock(clock), .reset(reset),
    .I_Cmd_Valid(I_Cmd_Valid), .O_Cmd_Ready(O_Cmd_Ready), .I_Cmd_Dir(I_Cmd_Dir),
    .I_Cmd_Base(I_Cmd_Base), .I_Cmd_Stride(I_Cmd_Stride), .I_Cmd_Length(I_Cmd_Length),
    .I_St_Valid(I_St_Valid), .I_St_Data(I_St_Data), .O_St_Ready(O_St_Ready),
    .O_Ld_Valid(O_Ld_Valid), .O_Ld_Data(O_Ld_Data), .O_Ld_Last(O_Ld_Last),
    .I_Ld_Ready(I_Ld_Ready), .O_Done(O_Done),
    .O_Mem_Req(O_Mem_Req), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
    .O_Mem_WData(O_Mem_WData), .I_Mem_Gnt(I_Mem_Gnt), .I_Mem_RValid(I_Mem_RValid),
    .I_Mem_RData(I_Mem_RData), .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // two-cycle read-latency model, shifted once per cycle by the driving task
  logic          lat_v [3];
  logic [WD-1:0] lat_d [3];

  // observations gathered by do_load
  logic [WA-1:0] g_addr [$];
  logic [WD-1:0] p_data [$];
  logic          p_last [$];
  logic [NC-1:0] cmd_rdy_obs;
  int            grants_at_hold;
  logic          req_at_hold, done_seen, stray;

  function automatic logic [WD-1:0] mem_word(input logic [WA-1:0] a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  task automatic idle_inputs();
    I_Cmd_Valid = '0; I_Cmd_Dir = '0; I_Cmd_Base = '0; I_Cmd_Stride = '0;
    I_Cmd_Length = '0; I_St_Valid = '0; I_St_Data = '0; I_Ld_Ready = '0;
    I_Mem_Gnt = 1'b1; I_Mem_RValid = 1'b0; I_Mem_RData = '0;
    for (int i = 0; i < 3; i++) begin lat_v[i] = 1'b0; lat_d[i] = '0; end
  endtask

  task automatic shift_ret();
    lat_v[0] = lat_v[1]; lat_d[0] = lat_d[1];
    lat_v[1] = lat_v[2]; lat_d[1] = lat_d[2];
    lat_v[2] = 1'b0;     lat_d[2] = '0;
    I_Mem_RValid = lat_v[0];
    I_Mem_RData  = lat_v[0] ? lat_d[0] : '0;
  endtask

  // runs one load descriptor to completion; I_Ld_Ready held low for 'hold' cycles
  task automatic do_load(input int ch, input logic [WA-1:0] base, input logic [WA-1:0] stride,
                         input logic [WL-1:0] len, input int hold);
    g_addr.delete(); p_data.delete(); p_last.delete();
    done_seen = 1'b0; stray = 1'b0; grants_at_hold = -1; req_at_hold = 1'b1;
    @(posedge clock); #1;
    I_Cmd_Valid[ch] = 1'b1; I_Cmd_Dir[ch] = 1'b0; I_Cmd_Base[ch] = base;
    I_Cmd_Stride[ch] = stride; I_Cmd_Length[ch] = len;
    shift_ret();
    #1;
    cmd_rdy_obs = O_Cmd_Ready;
    for (int cyc = 1; cyc < 300 && !done_seen; cyc++) begin
      @(posedge clock); #1;
      I_Cmd_Valid = '0;
      shift_ret();
      I_Ld_Ready = '0;
      I_Ld_Ready[ch] = (cyc > hold);
      #1;
      if (O_Mem_Req && I_Mem_Gnt) begin
        g_addr.push_back(O_Mem_Addr);
        lat_v[2] = 1'b1;
        lat_d[2] = mem_word(O_Mem_Addr);
      end
      if (O_Ld_Valid[ch] && I_Ld_Ready[ch]) begin
        p_data.push_back(O_Ld_Data[ch]);
        p_last.push_back(O_Ld_Last[ch]);
      end
      if ((O_Ld_Valid & ~(NC'(1) << ch)) != '0 || (O_Done & ~(NC'(1) << ch)) != '0) stray = 1'b1;
      if (cyc == hold) begin grants_at_hold = g_addr.size(); req_at_hold = O_Mem_Req; end
      if (O_Done[ch]) done_seen = 1'b1;
    end
    I_Ld_Ready = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    I_Cmd_Valid = 2'b11; I_St_Valid = 2'b11; I_Cmd_Length = {10'd3, 10'd3};
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #2;
      checks++;
      if ({O_Cmd_Ready, O_St_Ready, O_Ld_Valid, O_Ld_Data, O_Ld_Last, O_Done, O_Mem_Req,
           O_Mem_We, O_Mem_Addr, O_Mem_WData, O_Busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: cmd_rdy=%b req=%b busy=%b done=%b expected all zero",
                 k, O_Cmd_Ready, O_Mem_Req, O_Busy, O_Done);
      end
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_store();
    logic [WD-1:0] dat [3];
    logic [WA-1:0] ea   [3];
    dat = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    ea  = '{10'h010, 10'h012, 10'h014};
    @(posedge clock); #1;
    I_Cmd_Valid[0] = 1'b1; I_Cmd_Dir[0] = 1'b1; I_Cmd_Base[0] = 10'h010;
    I_Cmd_Stride[0] = 10'd2; I_Cmd_Length[0] = 10'd3;
    #1;
    checks++;
    if (O_Cmd_Ready !== 2'b01) begin errors++; $display("FAIL store_cmd_ready: got %b expected 01", O_Cmd_Ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      I_Cmd_Valid = '0; I_St_Valid[0] = 1'b1; I_St_Data[0] = dat[k];
      #1;
      checks++;
      if ({O_Mem_Req, O_Mem_We, O_St_Ready} !== 4'b1101) begin
        errors++; $display("FAIL store_req[%0d]: req=%b we=%b st_rdy=%b expected 1 1 01", k, O_Mem_Req, O_Mem_We, O_St_Ready);
      end
      checks++;
      if (O_Mem_Addr !== ea[k]) begin errors++; $display("FAIL store_addr[%0d]: got %h expected %h", k, O_Mem_Addr, ea[k]); end
      checks++;
      if (O_Mem_WData !== dat[k]) begin errors++; $display("FAIL store_wdata[%0d]: got %h expected %h", k, O_Mem_WData, dat[k]); end
    end
    @(posedge clock); #1;
    I_St_Valid = '0; I_St_Data = '0;
    #1;
    checks++;
    if ({O_Done, O_Mem_Req, O_Busy} !== 4'b0101) begin
      errors++; $display("FAIL store_done: done=%b req=%b busy=%b expected 01 0 1", O_Done, O_Mem_Req, O_Busy);
    end
    @(posedge clock); #2;
    checks++;
    if ({O_Done, O_Busy} !== 3'b000) begin errors++; $display("FAIL store_idle: done=%b busy=%b expected 00 0", O_Done, O_Busy); end
  endtask

  task automatic test_load();
    logic [WA-1:0] ea [4];
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    do_load(1, 10'h3FE, 10'd1, 10'd4, 0);
    checks++;
    if (cmd_rdy_obs !== 2'b10) begin errors++; $display("FAIL load_cmd_ready: got %b expected 10", cmd_rdy_obs); end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL load_done: no O_Done[1] within cycle budget"); end
    checks++;
    if (stray) begin errors++; $display("FAIL load_other_ch: got activity on ch0 expected none"); end
    checks++;
    if (g_addr.size() != 4 || p_data.size() != 4) begin
      errors++; $display("FAIL load_counts: grants=%0d pops=%0d expected 4 4", g_addr.size(), p_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g_addr[k] !== ea[k]) begin errors++; $display("FAIL load_addr[%0d]: got %h expected %h", k, g_addr[k], ea[k]); end
        checks++;
        if (p_data[k] !== mem_word(ea[k])) begin errors++; $display("FAIL load_data[%0d]: got %h expected %h", k, p_data[k], mem_word(ea[k])); end
        checks++;
        if (p_last[k] !== (k == 3)) begin errors++; $display("FAIL load_last[%0d]: got %b expected %b", k, p_last[k], k == 3); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_load(0, 10'h100, 10'd4, 10'd8, 10);
    checks++;
    if (grants_at_hold != 4) begin errors++; $display("FAIL bp_grants: got %0d expected 4", grants_at_hold); end
    checks++;
    if (req_at_hold !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b expected 0", req_at_hold); end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL bp_done: no O_Done[0] within cycle budget"); end
    checks++;
    if (p_data.size() != 8) begin
      errors++; $display("FAIL bp_pops: got %0d expected 8", p_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        logic [WA-1:0] a;
        a = 10'h100 + 10'(4 * k);
        checks++;
        if (p_data[k] !== mem_word(a)) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, p_data[k], mem_word(a)); end
      end
      checks++;
      if ({p_last[6], p_last[7]} !== 2'b01) begin errors++; $display("FAIL bp_last: got %b%b expected 01", p_last[6], p_last[7]); end
    end
  endtask

  task automatic test_zero_len();
    @(posedge clock); #1;
    I_Cmd_Valid[0] = 1'b1; I_Cmd_Dir[0] = 1'b0; I_Cmd_Length[0] = '0; I_Cmd_Base[0] = 10'h055;
    #1;
    checks++;
    if (O_Cmd_Ready !== 2'b01) begin errors++; $display("FAIL zero_cmd_ready: got %b expected 01", O_Cmd_Ready); end
    @(posedge clock); #1;
    I_Cmd_Valid = '0;
    #1;
    checks++;
    if ({O_Done, O_Mem_Req, O_Busy} !== 4'b0101) begin
      errors++; $display("FAIL zero_done: done=%b req=%b busy=%b expected 01 0 1", O_Done, O_Mem_Req, O_Busy);
    end
    @(posedge clock); #2;
    checks++;
    if ({O_Done, O_Mem_Req, O_Busy} !== 4'b0000) begin
      errors++; $display("FAIL zero_idle: done=%b req=%b busy=%b expected 00 0 0", O_Done, O_Mem_Req, O_Busy);
    end
  endtask

  task automatic test_arbitration();
    int order [$];
    int acc0, acc1;
    acc0 = 0; acc1 = 0;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    I_Cmd_Dir = 2'b11; I_Cmd_Length = {10'd1, 10'd1};
    I_Cmd_Base = {10'h200, 10'h100}; I_Cmd_Stride = {10'd1, 10'd1};
    I_St_Valid = 2'b11; I_St_Data = {32'h1111_1111, 32'h0000_0000};
    for (int cyc = 0; cyc < 40 && order.size() < 3; cyc++) begin
      @(posedge clock); #1;
      I_Cmd_Valid[0] = (acc0 < 2);
      I_Cmd_Valid[1] = (acc1 < 1);
      #1;
      if (O_Cmd_Ready[0]) begin order.push_back(0); acc0++; end
      if (O_Cmd_Ready[1]) begin order.push_back(1); acc1++; end
    end
    @(posedge clock); #1;
    I_Cmd_Valid = '0;
    repeat (3) @(posedge clock);
    #1 idle_inputs();
    checks++;
    if (order.size() != 3) begin
      errors++; $display("FAIL arb_count: got %0d acceptances expected 3", order.size());
    end else begin
      checks++;
      if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
        errors++; $display("FAIL arb_order: got %0d,%0d,%0d expected 0,1,0", order[0], order[1], order[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1;
    I_Cmd_Valid[0] = 1'b1; I_Cmd_Dir[0] = 1'b0; I_Cmd_Base[0] = 10'h200;
    I_Cmd_Stride[0] = 10'd1; I_Cmd_Length[0] = 10'd8;
    shift_ret();
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      I_Cmd_Valid = '0;
      shift_ret();
      #1;
      checks++;
      if (O_Mem_Req !== 1'b1) begin errors++; $display("FAIL rmid_req[%0d]: got %b expected 1", k, O_Mem_Req); end
      if (O_Mem_Req && I_Mem_Gnt) begin lat_v[2] = 1'b1; lat_d[2] = mem_word(O_Mem_Addr); end
    end
    @(posedge clock); #1;
    shift_ret();
    reset = 1'b1; I_Mem_Gnt = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    shift_ret();
    #1;
    checks++;
    if ({O_Cmd_Ready, O_St_Ready, O_Ld_Valid, O_Ld_Data, O_Ld_Last, O_Done, O_Mem_Req,
         O_Mem_We, O_Mem_Addr, O_Mem_WData, O_Busy} !== '0) begin
      errors++; $display("FAIL rmid_outputs: req=%b busy=%b ld_vld=%b done=%b expected all zero",
                         O_Mem_Req, O_Busy, O_Ld_Valid, O_Done);
    end
    @(posedge clock); #1;
    I_Mem_RValid = 1'b1; I_Mem_RData = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({O_Ld_Valid, O_Busy} !== 3'b000) begin errors++; $display("FAIL rmid_stray1: ld_vld=%b busy=%b expected 00 0", O_Ld_Valid, O_Busy); end
    @(posedge clock); #1;
    I_Mem_RValid = 1'b0; I_Mem_RData = '0;
    #1;
    checks++;
    if (O_Ld_Valid !== 2'b00) begin errors++; $display("FAIL rmid_stray2: ld_vld=%b expected 00", O_Ld_Valid); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_store();
    test_load();
    test_backpressure();
    test_zero_len();
    test_arbitration();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
